ahb_decoder_mux: RTL and testbench
==================================

AHB_DECODER_MUX -- requirements
Module: ahb_decoder_mux

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset: HCLK clocks all state; HRESETn is asynchronous and active-low.
REQ-002 HCLK  in  1  bus clock; all state updates on its rising edge.
REQ-003 HRESETn  in  1  asynchronous active-low reset.
REQ-004 HADDR  in  32  master address-phase address.
REQ-005 HTRANS  in  2  master transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-006 HSEL_ROM / HSEL_RAM / HSEL_PER  out  1 each  slave selects, combinational from HADDR.
REQ-007 HRDATA_ROM / HRDATA_RAM / HRDATA_PER  in  32 each  slave read data.
REQ-008 HREADYOUT_ROM / HREADYOUT_RAM / HREADYOUT_PER  in  1 each  slave ready responses.
REQ-009 HRESP_ROM / HRESP_RAM / HRESP_PER  in  2 each  slave responses: 00 OKAY, 01 ERROR.
REQ-010 HRDATA  out  32  muxed read data to master.
REQ-011 HREADY  out  1  muxed ready; drives the master and every slave's HREADY input.
REQ-012 HRESP  out  2  muxed response to master.
REQ-013 ERR_CLR  in  1  synchronous clear of ERR_CNT.
REQ-014 ERR_CNT  out  16  count of default-slave ERROR responses.

Function
REQ-015 Address decoding SHALL use HADDR[31:29]: 000 selects ROM, 001 selects RAM, 010 selects PER, and any other value selects the internal default slave.
REQ-016 Exactly one HSEL_* SHALL be high when HADDR decodes to ROM, RAM or PER; all are low when it decodes to the default slave. HSEL_* SHALL be independent of HTRANS.
REQ-017 The data-phase select register SHALL load the decoded slave index only on cycles where HREADY=1, and SHALL hold its value while HREADY=0.
REQ-018 HRDATA, HREADY and HRESP SHALL be combinational muxes of the slave named by the data-phase select register.
REQ-019 When the default slave is selected, HRDATA SHALL be 32'h0000_0000.
REQ-020 Default-slave FSM: three states, DS_IDLE, DS_ERR1 and DS_ERR2.
REQ-021 DS_IDLE: drives HREADY=1 and HRESP=OKAY. When HREADY=1, the address decodes to the default slave and HTRANS is NONSEQ or SEQ, the FSM SHALL move to DS_ERR1.
REQ-022 DS_ERR1: drives HREADY=0 and HRESP=ERROR, then moves unconditionally to DS_ERR2.
REQ-023 DS_ERR2: drives HREADY=1 and HRESP=ERROR. It moves to DS_ERR1 if another qualifying default transfer is accepted in this cycle; otherwise it moves to DS_IDLE.
REQ-024 IDLE or BUSY transfers to an unmapped address SHALL get a zero-wait OKAY response and SHALL NOT increment ERR_CNT.
REQ-025 ERR_CNT SHALL increment by 1 on every entry to DS_ERR1, and SHALL saturate at 16'hFFFF.
REQ-026 When ERR_CLR and an increment occur in the same cycle, ERR_CNT SHALL become 1. ERR_CLR alone SHALL set ERR_CNT to 0.
REQ-027 A slave wait state (HREADYOUT_x=0) SHALL stall address-phase acceptance; a new HADDR presented during the stall SHALL NOT change the data-phase select.
REQ-028 The transfer-to-response latency SHALL be exactly one cycle plus the selected slave's wait states. Default-slave errors SHALL take two data-phase cycles.

Reset
REQ-029 While HRESETn=0, the data-phase select SHALL be the default slave, the FSM SHALL be in DS_IDLE, and ERR_CNT SHALL be 0.
REQ-030 As a result, during reset the outputs SHALL be HREADY=1, HRESP=OKAY and HRDATA=0.
REQ-031 Reset asserted mid-transfer, including in DS_ERR1, SHALL abort the transfer immediately with no partial response.

Structure
REQ-032 The shared package ahb_bus_pkg SHALL hold: the HTRANS and HRESP encodings, the region codes for HADDR[31:29], the slave-index enumeration and the default HRDATA constant.
REQ-033 The default slave FSM and ERR_CNT SHALL be in one sub-module, ahb_default_slave. Decode, select register and muxing SHALL stay in the top module.

Verification
REQ-034 NONSEQ write to 0x2000_0010 with HREADYOUT_RAM=1 -> HSEL_RAM=1 in the address phase; in the next cycle HREADY=1 and HRESP=OKAY.
REQ-035 NONSEQ read to 0x0000_0004 with HREADYOUT_ROM low for 2 cycles and HRDATA_ROM=32'hCAFE_F00D -> HREADY=0 for 2 cycles, then 32'hCAFE_F00D with OKAY; a HADDR change during the stall does not alter the select.
REQ-036 NONSEQ to 0xE000_0000 -> no HSEL_* asserted; next cycle HREADY=0 with ERROR, following cycle HREADY=1 with ERROR; ERR_CNT=1.
REQ-037 Back-to-back NONSEQ to 0x8000_0000 and 0xA000_0000 -> FSM follows ERR1, ERR2, ERR1, ERR2, IDLE; ERR_CNT=2. IDLE to 0xE000_0000 -> zero-wait OKAY and ERR_CNT unchanged.
REQ-038 Preload ERR_CNT to 16'hFFFF, then one more error -> ERR_CNT stays 16'hFFFF. ERR_CLR coincident with an error -> ERR_CNT=1.
REQ-039 Assert HRESETn=0 while the FSM is in DS_ERR1 -> outputs immediately become HREADY=1, HRESP=OKAY, HRDATA=0 and ERR_CNT=0.

Source files
------------

// File: rtl/ahb_bus_pkg.sv
// Shared AHB encodings, region codes, slave indices and response payload.
package ahb_bus_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned TRANS_W  = 2;
  localparam int unsigned RESP_W   = 2;
  localparam int unsigned REGION_W = 3;
  localparam int unsigned CNT_W    = 16;

  localparam logic [TRANS_W-1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [TRANS_W-1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [TRANS_W-1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [TRANS_W-1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [RESP_W-1:0] HRESP_OKAY  = 2'b00;
  localparam logic [RESP_W-1:0] HRESP_ERROR = 2'b01;

  localparam logic [REGION_W-1:0] REGION_ROM = 3'b000;
  localparam logic [REGION_W-1:0] REGION_RAM = 3'b001;
  localparam logic [REGION_W-1:0] REGION_PER = 3'b010;

  localparam logic [DATA_W-1:0] HRDATA_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    SLV_ROM = 2'd0,
    SLV_RAM = 2'd1,
    SLV_PER = 2'd2,
    SLV_DEF = 2'd3
  } slv_idx_e;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic [RESP_W-1:0] resp;
  } ahb_rsp_t;

  // Map the top address bits onto a slave index; unmapped goes to the default slave.
  function automatic slv_idx_e decode_region(input logic [REGION_W-1:0] region);
    case (region)
      REGION_ROM: return SLV_ROM;
      REGION_RAM: return SLV_RAM;
      REGION_PER: return SLV_PER;
      default:    return SLV_DEF;
    endcase
  endfunction

  // NONSEQ and SEQ are the only transfer types that carry data.
  function automatic logic is_active(input logic [TRANS_W-1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle ERROR response for active transfers to unmapped space,
// plus a saturating count of those errors.
module ahb_default_slave
  import ahb_bus_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hready,
  input  logic               sel_def,
  input  logic [TRANS_W-1:0] htrans,
  input  logic               err_clr,
  output logic               ds_hready,
  output logic [RESP_W-1:0]  ds_hresp,
  output logic [CNT_W-1:0]   err_cnt
);

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  ds_state_e         state_q, state_d;
  logic              hready_d;
  logic [RESP_W-1:0] hresp_d;
  logic              accept;
  logic              err_inc;

  assign accept = hready && sel_def && is_active(htrans);

  // State and the state-derived response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DS_IDLE;
      ds_hready <= 1'b1;
      ds_hresp  <= HRESP_OKAY;
    end else begin
      state_q   <= state_d;
      ds_hready <= hready_d;
      ds_hresp  <= hresp_d;
    end
  end

  // Next state, next response and error-count increment.
  always_comb begin
    state_d  = state_q;
    hready_d = 1'b1;
    hresp_d  = HRESP_OKAY;
    err_inc  = 1'b0;
    case (state_q)
      DS_IDLE: begin
        if (accept) begin
          state_d = DS_ERR1;
          err_inc = 1'b1;
        end
      end
      DS_ERR1: begin
        state_d = DS_ERR2;
      end
      DS_ERR2: begin
        if (accept) begin
          state_d = DS_ERR1;
          err_inc = 1'b1;
        end else begin
          state_d = DS_IDLE;
        end
      end
      default: begin
        state_d = DS_IDLE;
      end
    endcase
    case (state_d)
      DS_ERR1: begin
        hready_d = 1'b0;
        hresp_d  = HRESP_ERROR;
      end
      DS_ERR2: begin
        hready_d = 1'b1;
        hresp_d  = HRESP_ERROR;
      end
      default: begin
        hready_d = 1'b1;
        hresp_d  = HRESP_OKAY;
      end
    endcase
  end

  // Saturating error counter; a clear wins over history but not over a same-cycle error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= CNT_W'(err_inc);
    end else if (err_inc && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB address decoder and slave response multiplexer with a built-in default slave.
module ahb_decoder_mux
  import ahb_bus_pkg::*;
(
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [ADDR_W-1:0]  HADDR,
  input  logic [TRANS_W-1:0] HTRANS,
  output logic               HSEL_ROM,
  output logic               HSEL_RAM,
  output logic               HSEL_PER,
  input  logic [DATA_W-1:0]  HRDATA_ROM,
  input  logic [DATA_W-1:0]  HRDATA_RAM,
  input  logic [DATA_W-1:0]  HRDATA_PER,
  input  logic               HREADYOUT_ROM,
  input  logic               HREADYOUT_RAM,
  input  logic               HREADYOUT_PER,
  input  logic [RESP_W-1:0]  HRESP_ROM,
  input  logic [RESP_W-1:0]  HRESP_RAM,
  input  logic [RESP_W-1:0]  HRESP_PER,
  output logic [DATA_W-1:0]  HRDATA,
  output logic               HREADY,
  output logic [RESP_W-1:0]  HRESP,
  input  logic               ERR_CLR,
  output logic [CNT_W-1:0]   ERR_CNT
);

  slv_idx_e          addr_slv;
  slv_idx_e          dsel_q;
  logic              sel_def;
  logic              ds_hready;
  logic [RESP_W-1:0] ds_hresp;
  ahb_rsp_t          rsp;
  logic              unused_addr_bits;

  // Address-phase decode; only the region bits matter here.
  assign addr_slv         = decode_region(HADDR[ADDR_W-1 -: REGION_W]);
  assign sel_def          = (addr_slv == SLV_DEF);
  assign HSEL_ROM         = (addr_slv == SLV_ROM);
  assign HSEL_RAM         = (addr_slv == SLV_RAM);
  assign HSEL_PER         = (addr_slv == SLV_PER);
  assign unused_addr_bits = ^HADDR[ADDR_W-REGION_W-1:0];

  // Data-phase select follows the address phase only when the bus is ready.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_q <= SLV_DEF;
    end else if (HREADY) begin
      dsel_q <= addr_slv;
    end
  end

  // Response mux for the slave owning the current data phase.
  always_comb begin
    rsp = '{rdata: HRDATA_DEFAULT, ready: ds_hready, resp: ds_hresp};
    case (dsel_q)
      SLV_ROM: rsp = '{rdata: HRDATA_ROM, ready: HREADYOUT_ROM, resp: HRESP_ROM};
      SLV_RAM: rsp = '{rdata: HRDATA_RAM, ready: HREADYOUT_RAM, resp: HRESP_RAM};
      SLV_PER: rsp = '{rdata: HRDATA_PER, ready: HREADYOUT_PER, resp: HRESP_PER};
      default: rsp = '{rdata: HRDATA_DEFAULT, ready: ds_hready, resp: ds_hresp};
    endcase
  end

  assign HRDATA = rsp.rdata;
  assign HREADY = rsp.ready;
  assign HRESP  = rsp.resp;

  ahb_default_slave u_def (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .hready    (HREADY),
    .sel_def   (sel_def),
    .htrans    (HTRANS),
    .err_clr   (ERR_CLR),
    .ds_hready (ds_hready),
    .ds_hresp  (ds_hresp),
    .err_cnt   (ERR_CNT)
  );

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Self-checking bench for ahb_decoder_mux: directed scenarios plus a randomized
// transfer stream checked against a transfer-level response model.
module tb_ahb_decoder_mux;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] R_OK   = 2'b00;
  localparam logic [1:0] R_ERR  = 2'b01;
  localparam logic [31:0] IDLE_ADDR = 32'hFFFF_FFF0;

  logic        HCLK, HRESETn;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HSEL_ROM, HSEL_RAM, HSEL_PER;
  logic [31:0] HRDATA_ROM, HRDATA_RAM, HRDATA_PER;
  logic        HREADYOUT_ROM, HREADYOUT_RAM, HREADYOUT_PER;
  logic [1:0]  HRESP_ROM, HRESP_RAM, HRESP_PER;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic        ERR_CLR;
  logic [15:0] ERR_CNT;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          slv;    // 0 ROM, 1 RAM, 2 PER, 3 default
    logic [1:0]  trans;
    logic [31:0] addr;
    int          waits;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } xfer_t;

  ahb_decoder_mux dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSEL_ROM(HSEL_ROM), .HSEL_RAM(HSEL_RAM), .HSEL_PER(HSEL_PER),
    .HRDATA_ROM(HRDATA_ROM), .HRDATA_RAM(HRDATA_RAM), .HRDATA_PER(HRDATA_PER),
    .HREADYOUT_ROM(HREADYOUT_ROM), .HREADYOUT_RAM(HREADYOUT_RAM), .HREADYOUT_PER(HREADYOUT_PER),
    .HRESP_ROM(HRESP_ROM), .HRESP_RAM(HRESP_RAM), .HRESP_PER(HRESP_PER),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .ERR_CLR(ERR_CLR), .ERR_CNT(ERR_CNT)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task drive_idle;
    HADDR = IDLE_ADDR; HTRANS = T_IDLE; ERR_CLR = 1'b0;
    HREADYOUT_ROM = 1'b1; HREADYOUT_RAM = 1'b1; HREADYOUT_PER = 1'b1;
    HRESP_ROM = R_OK; HRESP_RAM = R_OK; HRESP_PER = R_OK;
    HRDATA_ROM = 32'h1111_1111; HRDATA_RAM = 32'h2222_2222; HRDATA_PER = 32'h3333_3333;
  endtask

  task do_reset;
    @(negedge HCLK);
    HRESETn = 1'b0;
    drive_idle();
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  task test_reset;
    @(negedge HCLK);
    HRESETn = 1'b0;
    HADDR = 32'hE000_0000; HTRANS = T_NSEQ;
    HREADYOUT_ROM = 1'b0; HREADYOUT_RAM = 1'b0; HREADYOUT_PER = 1'b0;
    @(negedge HCLK); #1;
    n_tests++;
    if ({HREADY, HRESP, HRDATA, ERR_CNT} !== {1'b1, R_OK, 32'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b resp=%0h rdata=%0h cnt=%0h required 1/0/0/0",
               HREADY, HRESP, HRDATA, ERR_CNT);
    end
    HRESETn = 1'b1;
    drive_idle();
  endtask

  task test_ram_write;
    do_reset();
    @(negedge HCLK);
    HADDR = 32'h2000_0010; HTRANS = T_NSEQ;
    #1;
    n_tests++;
    if ({HSEL_PER, HSEL_RAM, HSEL_ROM} !== 3'b010) begin
      n_fail++;
      $display("FAIL ram_hsel: got %b required 010", {HSEL_PER, HSEL_RAM, HSEL_ROM});
    end
    @(negedge HCLK);
    HADDR = IDLE_ADDR; HTRANS = T_IDLE;
    HRDATA_RAM = 32'hA5A5_0001; HREADYOUT_RAM = 1'b1; HRESP_RAM = R_OK;
    HREADYOUT_ROM = 1'b0; HRESP_ROM = R_ERR; HREADYOUT_PER = 1'b0; HRESP_PER = R_ERR;
    #1;
    n_tests++;
    if ({HREADY, HRESP, HRDATA} !== {1'b1, R_OK, 32'hA5A5_0001}) begin
      n_fail++;
      $display("FAIL ram_dphase: got ready=%b resp=%0h rdata=%0h required 1/0/a5a50001",
               HREADY, HRESP, HRDATA);
    end
  endtask

  task test_rom_wait;
    do_reset();
    @(negedge HCLK);
    HADDR = 32'h0000_0004; HTRANS = T_NSEQ;
    @(negedge HCLK);
    HREADYOUT_ROM = 1'b0; HRDATA_ROM = 32'hCAFE_F00D;
    HADDR = 32'h2000_0000; HTRANS = T_NSEQ; HRDATA_RAM = 32'h1234_5678;
    #1;
    n_tests++;
    if (HREADY !== 1'b0) begin
      n_fail++;
      $display("FAIL rom_wait1: got ready=%b required 0", HREADY);
    end
    @(negedge HCLK);
    HADDR = 32'h4000_0000;
    #1;
    n_tests++;
    if (HREADY !== 1'b0) begin
      n_fail++;
      $display("FAIL rom_wait2: got ready=%b required 0", HREADY);
    end
    @(negedge HCLK);
    HREADYOUT_ROM = 1'b1; HADDR = IDLE_ADDR; HTRANS = T_IDLE;
    #1;
    n_tests++;
    if ({HREADY, HRESP, HRDATA} !== {1'b1, R_OK, 32'hCAFE_F00D}) begin
      n_fail++;
      $display("FAIL rom_data: got ready=%b resp=%0h rdata=%0h required 1/0/cafef00d",
               HREADY, HRESP, HRDATA);
    end
    @(negedge HCLK); #1;
    n_tests++;
    if ({HREADY, HRESP, HRDATA} !== {1'b1, R_OK, 32'h0}) begin
      n_fail++;
      $display("FAIL rom_after: got ready=%b resp=%0h rdata=%0h required 1/0/0",
               HREADY, HRESP, HRDATA);
    end
  endtask

  task test_default_err;
    do_reset();
    @(negedge HCLK);
    HADDR = 32'hE000_0000; HTRANS = T_NSEQ;
    #1;
    n_tests++;
    if ({HSEL_PER, HSEL_RAM, HSEL_ROM} !== 3'b000) begin
      n_fail++;
      $display("FAIL def_hsel: got %b required 000", {HSEL_PER, HSEL_RAM, HSEL_ROM});
    end
    @(negedge HCLK);
    HADDR = IDLE_ADDR; HTRANS = T_IDLE;
    #1;
    n_tests++;
    if ({HREADY, HRESP, ERR_CNT} !== {1'b0, R_ERR, 16'd1}) begin
      n_fail++;
      $display("FAIL def_err1: got ready=%b resp=%0h cnt=%0d required 0/1/1", HREADY, HRESP, ERR_CNT);
    end
    @(negedge HCLK); #1;
    n_tests++;
    if ({HREADY, HRESP, HRDATA} !== {1'b1, R_ERR, 32'h0}) begin
      n_fail++;
      $display("FAIL def_err2: got ready=%b resp=%0h rdata=%0h required 1/1/0", HREADY, HRESP, HRDATA);
    end
    @(negedge HCLK); #1;
    n_tests++;
    if ({HREADY, HRESP, ERR_CNT} !== {1'b1, R_OK, 16'd1}) begin
      n_fail++;
      $display("FAIL def_done: got ready=%b resp=%0h cnt=%0d required 1/0/1", HREADY, HRESP, ERR_CNT);
    end
  endtask

  task test_back_to_back;
    logic [31:0] addr_t [6];
    logic [1:0]  trans_t [6];
    logic        rdy_t [6];
    logic [1:0]  resp_t [6];
    logic [15:0] cnt_t [6];
    addr_t  = '{32'hA000_0000, 32'hA000_0000, 32'hE000_0000, 32'hE000_0000, 32'hE000_0000, 32'hE000_0000};
    trans_t = '{T_NSEQ, T_NSEQ, T_IDLE, T_IDLE, T_IDLE, T_IDLE};
    rdy_t   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    resp_t  = '{R_ERR, R_ERR, R_ERR, R_ERR, R_OK, R_OK};
    cnt_t   = '{16'd1, 16'd1, 16'd2, 16'd2, 16'd2, 16'd2};
    do_reset();
    @(negedge HCLK);
    HADDR = 32'h8000_0000; HTRANS = T_NSEQ;
    for (int c = 0; c < 6; c++) begin
      @(negedge HCLK);
      HADDR = addr_t[c]; HTRANS = trans_t[c];
      #1;
      n_tests++;
      if ({HREADY, HRESP, HRDATA, ERR_CNT} !== {rdy_t[c], resp_t[c], 32'h0, cnt_t[c]}) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: got ready=%b resp=%0h rdata=%0h cnt=%0d required %b/%0h/0/%0d",
                 c, HREADY, HRESP, HRDATA, ERR_CNT, rdy_t[c], resp_t[c], cnt_t[c]);
      end
    end
  endtask

  task test_saturation;
    do_reset();
    @(negedge HCLK);
    force dut.u_def.err_cnt = 16'hFFFE;
    #1 release dut.u_def.err_cnt;
    @(negedge HCLK);
    HADDR = 32'hE000_0000; HTRANS = T_NSEQ;
    @(negedge HCLK);
    HADDR = 32'hC000_0000;
    #1;
    n_tests++;
    if (ERR_CNT !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_reach: got cnt=%0h required ffff", ERR_CNT);
    end
    @(negedge HCLK);
    @(negedge HCLK);
    HADDR = IDLE_ADDR; HTRANS = T_IDLE;
    #1;
    n_tests++;
    if (ERR_CNT !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_hold: got cnt=%0h required ffff", ERR_CNT);
    end
    @(negedge HCLK);
    @(negedge HCLK);
    HADDR = 32'hE000_0000; HTRANS = T_NSEQ; ERR_CLR = 1'b1;
    @(negedge HCLK);
    HADDR = IDLE_ADDR; HTRANS = T_IDLE; ERR_CLR = 1'b0;
    #1;
    n_tests++;
    if (ERR_CNT !== 16'd1) begin
      n_fail++;
      $display("FAIL clr_with_err: got cnt=%0h required 1", ERR_CNT);
    end
    @(negedge HCLK);
    @(negedge HCLK);
    ERR_CLR = 1'b1;
    @(negedge HCLK);
    ERR_CLR = 1'b0;
    #1;
    n_tests++;
    if (ERR_CNT !== 16'd0) begin
      n_fail++;
      $display("FAIL clr_alone: got cnt=%0h required 0", ERR_CNT);
    end
  endtask

  task test_reset_in_err1;
    do_reset();
    @(negedge HCLK);
    HADDR = 32'hE000_0000; HTRANS = T_NSEQ;
    @(negedge HCLK); #1;
    n_tests++;
    if ({HREADY, HRESP} !== {1'b0, R_ERR}) begin
      n_fail++;
      $display("FAIL rst_err1_pre: got ready=%b resp=%0h required 0/1", HREADY, HRESP);
    end
    #1 HRESETn = 1'b0;
    #1;
    n_tests++;
    if ({HREADY, HRESP, HRDATA, ERR_CNT} !== {1'b1, R_OK, 32'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL rst_err1_abort: got ready=%b resp=%0h rdata=%0h cnt=%0h required 1/0/0/0",
               HREADY, HRESP, HRDATA, ERR_CNT);
    end
    @(negedge HCLK);
    HRESETn = 1'b1; HADDR = IDLE_ADDR; HTRANS = T_IDLE;
    @(negedge HCLK); #1;
    n_tests++;
    if ({HREADY, HRESP, ERR_CNT} !== {1'b1, R_OK, 16'h0}) begin
      n_fail++;
      $display("FAIL rst_err1_after: got ready=%b resp=%0h cnt=%0h required 1/0/0", HREADY, HRESP, ERR_CNT);
    end
  endtask

  task test_random;
    xfer_t       q[$];
    xfer_t       x, cur, nxt;
    int          errs, len;
    logic        last, e_rdy;
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;
    logic [2:0]  region;
    logic [31:0] rd [3];
    logic        ry [3];
    logic [1:0]  rs [3];

    x = '{slv: 3, trans: T_IDLE, addr: IDLE_ADDR, waits: 0, rdata: 32'h0, resp: R_OK};
    q.push_back(x);
    for (int i = 0; i < 200; i++) begin
      region  = 3'($urandom_range(0, 7));
      x.slv   = (region < 3) ? int'(region) : 3;
      x.trans = 2'($urandom_range(0, 3));
      x.addr  = {region, 29'($urandom)};
      x.waits = (x.slv < 3 && x.trans[1]) ? $urandom_range(0, 2) : 0;
      x.rdata = $urandom;
      x.resp  = 2'($urandom_range(0, 1));
      q.push_back(x);
    end
    x = '{slv: 3, trans: T_IDLE, addr: IDLE_ADDR, waits: 0, rdata: 32'h0, resp: R_OK};
    q.push_back(x);

    do_reset();
    errs = 0;
    for (int i = 0; i < q.size() - 1; i++) begin
      cur = q[i];
      nxt = q[i + 1];
      if (cur.slv == 3) len = cur.trans[1] ? 2 : 1;
      else              len = cur.waits + 1;
      for (int j = 0; j < len; j++) begin
        @(negedge HCLK);
        last = (j == len - 1);
        if (last) begin
          HADDR = nxt.addr; HTRANS = nxt.trans;
        end else begin
          HADDR = $urandom; HTRANS = 2'($urandom_range(0, 3));
        end
        for (int s = 0; s < 3; s++) begin
          rd[s] = $urandom; ry[s] = 1'($urandom); rs[s] = 2'($urandom);
        end
        if (cur.slv < 3) begin
          rd[cur.slv] = cur.rdata;
          ry[cur.slv] = (j == cur.waits);
          rs[cur.slv] = (j == cur.waits) ? cur.resp : R_OK;
        end
        HRDATA_ROM = rd[0]; HRDATA_RAM = rd[1]; HRDATA_PER = rd[2];
        HREADYOUT_ROM = ry[0]; HREADYOUT_RAM = ry[1]; HREADYOUT_PER = ry[2];
        HRESP_ROM = rs[0]; HRESP_RAM = rs[1]; HRESP_PER = rs[2];
        if (cur.slv == 3) begin
          e_rdata = 32'h0;
          e_rdy   = cur.trans[1] ? (j == 1) : 1'b1;
          e_resp  = cur.trans[1] ? R_ERR : R_OK;
        end else begin
          e_rdata = cur.rdata;
          e_rdy   = (j == cur.waits);
          e_resp  = (j == cur.waits) ? cur.resp : R_OK;
        end
        region = HADDR[31:29];
        #1;
        n_tests++;
        if ({HSEL_PER, HSEL_RAM, HSEL_ROM} !== {region == 3'd2, region == 3'd1, region == 3'd0}) begin
          n_fail++;
          $display("FAIL rnd_hsel x%0d c%0d: got %b for addr %0h", i, j,
                   {HSEL_PER, HSEL_RAM, HSEL_ROM}, HADDR);
        end
        n_tests++;
        if ({HREADY, HRESP, HRDATA, ERR_CNT} !== {e_rdy, e_resp, e_rdata, 16'(errs)}) begin
          n_fail++;
          $display("FAIL rnd_rsp x%0d c%0d: got ready=%b resp=%0h rdata=%0h cnt=%0d required %b/%0h/%0h/%0d",
                   i, j, HREADY, HRESP, HRDATA, ERR_CNT, e_rdy, e_resp, e_rdata, errs);
        end
      end
      if (nxt.slv == 3 && nxt.trans[1]) errs++;
    end
    drive_idle();
  endtask

  initial begin
    HRESETn = 1'b0;
    drive_idle();
    test_reset();
    test_ram_write();
    test_rom_wait();
    test_default_err();
    test_back_to_back();
    test_saturation();
    test_reset_in_err1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
